pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program counter and sequencer for the computer core. Supersedes the bare 4-bit
//   free-running PC. Adds conditional jumps on ALU flags, stall, single-step mode, a terminal
//   halt address, sticky wrap detection and a retired-instruction counter.
//   Drives the instruction-memory address; the core feeds it jump fields and ALU flags.
// PARAMETERS
//   PC_W       4               PC / instruction-memory address width
//   RESET_ADDR 0               PC value after reset and after halt_clr
//   HALT_ADDR  (1<<PC_W)-1     reaching this address stops the sequencer
//   CNT_W      16              width of retire counter (saturating)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   en         in   1       1 = advance allowed this cycle; 0 = stall (PC holds)
//   step_mode  in   1       1 = advance only on step_req rising edge
//   step_req   in   1       single-step request (level; internally edge-detected)
//   jmp_en     in   1       instruction is a jump
//   jmp_cond   in   3       condition code (see BEHAVIOUR)
//   jmp_addr   in   PC_W    jump target
//   flags      in   4       ALU flags {V,C,N,Z}, valid same cycle as jmp_en
//   halt_clr   in   1       restart: PC<=RESET_ADDR, clear halt/wrap/count
//   pc         out  PC_W    current PC (registered)
//   halted     out  1       1 while in HALT state
//   wrapped    out  1       sticky: PC rolled from all-ones to 0
//   retire_cnt out  CNT_W   number of PC advances since reset/halt_clr, saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_ADDR, state=RUN, halted=0, wrapped=0, retire_cnt=0, step edge reg=0.
//   States: RUN, HALT. halted = (state==HALT). No other states.
//   adv = (state==RUN) & en & (step_mode ? step_rise : 1).
//     step_rise = step_req & ~step_req_q; step_req_q is registered every cycle regardless of en.
//   Condition codes: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 V.
//   take = jmp_en & cond_true(jmp_cond, flags).
//   pc_nxt = take ? jmp_addr : pc+1 (mod 2^PC_W).
//   On adv: pc<=pc_nxt; retire_cnt<=retire_cnt+1 unless saturated.
//     If ~take and pc==all-ones, set wrapped.
//     If pc_nxt==HALT_ADDR, state<=HALT. The transition occurs on the same edge that loads pc.
//   No adv: pc, count and state hold. jmp_en is ignored while stalled or halted.
//   HALT: pc holds at HALT_ADDR. en, step_req and jmp_* are ignored. Exit only via halt_clr or reset.
//   halt_clr (sync) has priority over adv in any state:
//     pc<=RESET_ADDR, state<=RUN, wrapped<=0, retire_cnt<=0.
//   RESET_ADDR==HALT_ADDR is illegal (elaboration-time check).
//   Latency: 1 cycle from qualifying inputs to new pc. All outputs are registered or decode of the state register.
//   Reset mid-operation: immediate async clear to reset values. No partial step survives.
// STRUCTURE
//   Shared package seq_pkg: condition-code localparams (COND_ALW..COND_V), state encodings
//   ST_RUN/ST_HALT, flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3).
//   Sub-module cond_eval: combinational (jmp_cond, flags) -> cond_true. The rest is flat:
//   state register, pc register, step edge detector, counter.
// TESTING
//   Free run, PC_W=4, en=1, no jumps -> pc 0,1,..,F, one per cycle. halted=1 on the edge loading F.
//     Then retire_cnt=15 and pc holds F for 10 more cycles.
//   Conditional jump: pc=3, jmp_en=1, cond=001, flags.Z=1, jmp_addr=9 -> pc=9.
//     Same with Z=0 -> pc=4. cond=000 always jumps.
//   Stall/step: en=0 for 5 cycles -> pc and count frozen.
//     step_mode=1, step_req held high 4 cycles -> exactly one advance.
//     Three separate pulses -> three advances.
//   Wrap: HALT_ADDR=5, RESET_ADDR=8, run from 8 -> 8..F,0..5. wrapped=1 after F->0, halted at 5.
//   halt_clr while halted with jmp_en=1 -> pc=RESET_ADDR, halted=0, wrapped=0, count=0.
//     jmp ignored.
//   Async reset asserted mid-run (pc=6, between clock edges) -> outputs at reset values
//     without waiting for a clock edge. Resume from RESET_ADDR after rst_n rises.
//   Saturation: CNT_W=3, 10 advances -> retire_cnt=7.

Source files
------------

// File: rtl/seq_pkg.sv
//------------------------------------------------------------------------------
// seq_pkg : condition codes, flag indices and state encoding for the PC sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

    localparam logic [2:0] COND_ALW = 3'b000;
    localparam logic [2:0] COND_Z   = 3'b001;
    localparam logic [2:0] COND_NZ  = 3'b010;
    localparam logic [2:0] COND_N   = 3'b011;
    localparam logic [2:0] COND_NN  = 3'b100;
    localparam logic [2:0] COND_C   = 3'b101;
    localparam logic [2:0] COND_NC  = 3'b110;
    localparam logic [2:0] COND_V   = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
//------------------------------------------------------------------------------
// cond_eval : decodes a jump condition code against the ALU flags {V,C,N,Z}
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cond_eval
    import seq_pkg::*;
(
    input  logic [2:0] jmp_cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (jmp_cond)
            COND_ALW: cond_true = 1'b1;
            COND_Z:   cond_true = flags[FLG_Z];
            COND_NZ:  cond_true = ~flags[FLG_Z];
            COND_N:   cond_true = flags[FLG_N];
            COND_NN:  cond_true = ~flags[FLG_N];
            COND_C:   cond_true = flags[FLG_C];
            COND_NC:  cond_true = ~flags[FLG_C];
            COND_V:   cond_true = flags[FLG_V];
            default:  cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer : program counter with conditional jumps, stall, single-step,
//                terminal halt address, sticky wrap flag and retire counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W       = 4,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned HALT_ADDR  = (1 << PC_W) - 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             jmp_en,
    input  logic [2:0]       jmp_cond,
    input  logic [PC_W-1:0]  jmp_addr,
    input  logic [3:0]       flags,
    input  logic             halt_clr,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             wrapped,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [PC_W-1:0] C_RESET_PC = RESET_ADDR[PC_W-1:0];
    localparam logic [PC_W-1:0] C_HALT_PC  = HALT_ADDR[PC_W-1:0];

    if (C_RESET_PC == C_HALT_PC) begin : g_bad_cfg
        $error("pc_sequencer: RESET_ADDR must differ from HALT_ADDR");
    end

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrapped_q, wrapped_d;
    logic             step_req_q, step_req_d;

    logic             cond_true;
    logic             step_rise;
    logic             adv;
    logic             take;
    logic [PC_W-1:0]  pc_nxt;

    cond_eval u_cond_eval (
        .jmp_cond  (jmp_cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    always_comb begin
        step_rise  = step_req & ~step_req_q;
        adv        = (state_q == ST_RUN) & en & (step_mode ? step_rise : 1'b1);
        take       = jmp_en & cond_true;
        pc_nxt     = take ? jmp_addr : pc_q + PC_W'(1);

        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        wrapped_d  = wrapped_q;
        step_req_d = step_req;

        // Restart wins over any advance, including one that would jump.
        if (halt_clr) begin
            state_d   = ST_RUN;
            pc_d      = C_RESET_PC;
            cnt_d     = '0;
            wrapped_d = 1'b0;
        end else if (adv) begin
            pc_d = pc_nxt;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!take && (&pc_q)) begin
                wrapped_d = 1'b1;
            end
            if (pc_nxt == C_HALT_PC) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= C_RESET_PC;
            cnt_q      <= '0;
            wrapped_q  <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            wrapped_q  <= wrapped_d;
            step_req_q <= step_req_d;
        end
    end

    assign pc         = pc_q;
    assign halted     = (state_q == ST_HALT);
    assign wrapped    = wrapped_q;
    assign retire_cnt = cnt_q;

endmodule

`default_nettype wire
